// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
// Bundles the producer/consumer requests and the controller's RAM-side and
// status outputs into one connection.
//   push, pop               : requests from producer / consumer
//   ram_we, ram_wr_addr     : write strobe and address to the RAM
//   ram_re, ram_rd_addr     : read strobe and address to the RAM
//   rd_valid                : RAM d_out holds the popped entry this cycle
//   full, empty, count      : occupancy status
//   overflow, underflow     : sticky error flags
// Modports: master = the side issuing push/pop and observing status,
//           slave  = the FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int ADDR = 4
);
    logic            push;
    logic            pop;
    logic            ram_we;
    logic [ADDR-1:0] ram_wr_addr;
    logic            ram_re;
    logic [ADDR-1:0] ram_rd_addr;
    logic            rd_valid;
    logic            full;
    logic            empty;
    logic [ADDR:0]   count;
    logic            overflow;
    logic            underflow;

    modport master (
        output push, pop,
        input  ram_we, ram_wr_addr, ram_re, ram_rd_addr,
        input  rd_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output ram_we, ram_wr_addr, ram_re, ram_rd_addr,
        output rd_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Pointer and flag controller that turns a synchronous-read dual-port RAM
// into a FIFO. Accepted pushes/pops become RAM write/read strobes on the
// same clock edge; occupancy is tracked by a counter from which full and
// empty are decoded.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : ram_fifo_ctrl_if.slave (requests in, RAM controls and status out)
module ram_fifo_ctrl #(
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.slave  bus
);
    localparam logic [ADDR-1:0] LAST_PTR  = ADDR'(DEPTH - 1);
    localparam logic [ADDR:0]   DEPTH_CNT = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0]   CNT_ONE   = (ADDR + 1)'(1);
    localparam logic [ADDR-1:0] PTR_ZERO  = {ADDR{1'b0}};
    localparam logic [ADDR-1:0] PTR_ONE   = ADDR'(1);

    logic [ADDR-1:0] wr_ptr_r;
    logic [ADDR-1:0] rd_ptr_r;
    logic [ADDR:0]   count_r;
    logic            full_r;
    logic            empty_r;
    logic            rd_valid_r;
    logic            overflow_r;
    logic            underflow_r;

    logic            push_ok_s;
    logic            pop_ok_s;
    logic [ADDR:0]   count_nxt_s;
    logic [ADDR-1:0] wr_ptr_nxt_s;
    logic [ADDR-1:0] rd_ptr_nxt_s;

    // Accept decisions; rst gates both so no RAM access happens in reset.
    // Full and empty are judged on current state only, so a simultaneous
    // pop never makes room for a push (no write-through) and a simultaneous
    // push never feeds a pop (no bypass).
    always_comb begin
        push_ok_s = bus.push & ~full_r  & ~rst;
        pop_ok_s  = bus.pop  & ~empty_r & ~rst;
    end

    // Occupancy update: both or neither accepted leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer advance with explicit wrap at the last RAM entry.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            if (wr_ptr_r == LAST_PTR) begin
                wr_ptr_nxt_s = PTR_ZERO;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            if (rd_ptr_r == LAST_PTR) begin
                rd_ptr_nxt_s = PTR_ZERO;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // State registers. full/empty are decoded from the next count so they
    // are registered alongside it rather than derived from pointer compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= {(ADDR + 1){1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_CNT);
            empty_r     <= (count_nxt_s == {(ADDR + 1){1'b0}});
            // RAM read is synchronous: d_out is valid the cycle after the pop.
            rd_valid_r  <= pop_ok_s;
            overflow_r  <= overflow_r  | (bus.push & full_r);
            underflow_r <= underflow_r | (bus.pop  & empty_r);
        end
    end

    // RAM controls are combinational so the RAM samples them on the same
    // edge that advances the pointers.
    always_comb begin
        bus.ram_we      = push_ok_s;
        bus.ram_wr_addr = wr_ptr_r;
        bus.ram_re      = pop_ok_s;
        bus.ram_rd_addr = rd_ptr_r;
        bus.rd_valid    = rd_valid_r;
        bus.full        = full_r;
        bus.empty       = empty_r;
        bus.count       = count_r;
        bus.overflow    = overflow_r;
        bus.underflow   = underflow_r;
    end
endmodule
